// File: rtl/wb_queue.sv
// Write-back queue for the register file write port: in-order FIFO of pending
// results, one registered write per granted cycle, with two bypass lookup ports.
module wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_reg,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     drain_en,
  output logic                     regWrite,
  output logic [ADDR_W-1:0]        writeR,
  output logic [DATA_W-1:0]        writeRData,
  input  logic [ADDR_W-1:0]        byp_reg1,
  input  logic [ADDR_W-1:0]        byp_reg2,
  output logic                     byp_hit1,
  output logic [DATA_W-1:0]        byp_data1,
  output logic                     byp_hit2,
  output logic [DATA_W-1:0]        byp_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } byp_t;

  logic [ADDR_W-1:0] r_reg  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic w_push;
  logic w_pop;
  byp_t w_byp1;
  byp_t w_byp2;

  assign in_ready = (r_count < CNT_W'(DEPTH));
  assign count    = r_count;
  assign empty    = (r_count == '0);

  // Register 0 completes the handshake but is never stored.
  assign w_push = in_valid && in_ready && (in_reg != '0);
  assign w_pop  = drain_en && (r_count != '0);

  // NOTE: storage has no reset; the pointers and count alone define which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_reg[r_tail]  <= in_reg;
      r_data[r_tail] <= in_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, e.g. the pop reads the head before it moves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      regWrite   <= 1'b0;
      writeR     <= '0;
      writeRData <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      regWrite <= w_pop;
      if (w_pop) begin
        writeR     <= r_reg[r_head];
        writeRData <= r_data[r_head];
      end
    end
  end

  // Scan oldest to youngest so the last match wins; the in-flight write is oldest.
  function automatic byp_t lookup(input logic [ADDR_W-1:0] key);
    byp_t             res;
    logic [PTR_W-1:0] idx;
    res = '0;
    if (key != '0) begin
      if (regWrite && (writeR == key)) begin
        res.hit  = 1'b1;
        res.data = writeRData;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = r_head + PTR_W'(i);
        if ((CNT_W'(i) < r_count) && (r_reg[idx] == key)) begin
          res.hit  = 1'b1;
          res.data = r_data[idx];
        end
      end
    end
    return res;
  endfunction

  // NOTE: every always_comb output is assigned unconditionally, so no latch.
  always_comb begin
    w_byp1 = lookup(byp_reg1);
    w_byp2 = lookup(byp_reg2);
  end

  assign byp_hit1  = w_byp1.hit;
  assign byp_data1 = w_byp1.data;
  assign byp_hit2  = w_byp2.hit;
  assign byp_data2 = w_byp2.data;

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_wb_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_reg = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              drain_en = 1'b0;
  logic              regWrite;
  logic [ADDR_W-1:0] writeR;
  logic [DATA_W-1:0] writeRData;
  logic [ADDR_W-1:0] byp_reg1 = '0;
  logic [ADDR_W-1:0] byp_reg2 = '0;
  logic              byp_hit1, byp_hit2;
  logic [DATA_W-1:0] byp_data1, byp_data2;
  logic [$clog2(DEPTH):0] count;
  logic              empty;

  wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .drain_en(drain_en),
    .regWrite(regWrite), .writeR(writeR), .writeRData(writeRData),
    .byp_reg1(byp_reg1), .byp_reg2(byp_reg2),
    .byp_hit1(byp_hit1), .byp_data1(byp_data1),
    .byp_hit2(byp_hit2), .byp_data2(byp_data2),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending results as a plain queue plus the write-port register.
  typedef struct {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              q[$];
  logic              m_rw = 1'b0;
  logic [ADDR_W-1:0] m_wr = '0;
  logic [DATA_W-1:0] m_wd = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_rw = 1'b0;
      m_wr = '0;
      m_wd = '0;
    end else begin
      bit   pop, acc;
      ent_t e;
      pop = drain_en && (q.size() > 0);
      acc = in_valid && (q.size() < DEPTH);
      if (pop) begin
        e    = q.pop_front();
        m_rw = 1'b1;
        m_wr = e.r;
        m_wd = e.d;
      end else begin
        m_rw = 1'b0;
      end
      if (acc && (in_reg != 0)) begin
        e.r = in_reg;
        e.d = in_data;
        q.push_back(e);
      end
    end
  end

  // Youngest pending value for a register; the in-flight write counts as oldest.
  function automatic void ref_byp(input logic [ADDR_W-1:0] k, output logic hit,
                                  output logic [DATA_W-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (k != 0) begin
      if (m_rw && (m_wr == k)) begin
        hit = 1'b1;
        d   = m_wd;
      end
      foreach (q[i]) if (q[i].r == k) begin
        hit = 1'b1;
        d   = q[i].d;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic              h;
      logic [DATA_W-1:0] d;
      check("count", 64'(count), 64'(q.size()));
      check("empty", 64'(empty), 64'(q.size() == 0));
      check("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
      check("regWrite", 64'(regWrite), 64'(m_rw));
      if (m_rw) begin
        check("writeR", 64'(writeR), 64'(m_wr));
        check("writeRData", 64'(writeRData), 64'(m_wd));
      end
      ref_byp(byp_reg1, h, d);
      check("byp_hit1", 64'(byp_hit1), 64'(h));
      check("byp_data1", 64'(byp_data1), 64'(d));
      ref_byp(byp_reg2, h, d);
      check("byp_hit2", 64'(byp_hit2), 64'(h));
      check("byp_data2", 64'(byp_data2), 64'(d));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [ADDR_W-1:0] r,
                       input logic [DATA_W-1:0] d, input logic dr);
    in_valid = v;
    in_reg   = r;
    in_data  = d;
    drain_en = dr;
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    chk_en = 1'b1;
    step();

    // Reset mid-operation with three entries pending and a write in flight.
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, ADDR_W'(k + 8), DATA_W'(32'hC0DE_0000 + k), 1'b0);
      step();
    end
    drive(1'b1, 5'd12, 32'hC0DE_0004, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0);
    check("pre_reset_rw", 64'(regWrite), 64'd1);
    check("pre_reset_cnt", 64'(count), 64'd3);
    rst = 1'b0;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_regWrite", 64'(regWrite), 64'd0);
    check("rst_writeR", 64'(writeR), 64'd0);
    step();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b1);
    repeat (3) step();
    check("post_reset_no_write", 64'(regWrite), 64'd0);

    // Single entry latency.
    drive(1'b1, 5'd5, 32'hAAAA_0001, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b1);
    check("lat_count", 64'(count), 64'd1);
    check("lat_rw_early", 64'(regWrite), 64'd0);
    step();
    check("lat_rw", 64'(regWrite), 64'd1);
    check("lat_wr", 64'(writeR), 64'd5);
    check("lat_wd", 64'(writeRData), 64'hAAAA_0001);
    step();
    check("lat_rw_after", 64'(regWrite), 64'd0);

    // Fill to full, fifth entry refused, then drain across the pointer wrap.
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, ADDR_W'(k), DATA_W'(k * 32'h100), 1'b0);
      step();
      if (k == 4) check("full_ready", 64'(in_ready), 64'd0);
    end
    drive(1'b0, '0, '0, 1'b0);
    check("full_count", 64'(count), 64'd4);
    drive(1'b0, '0, '0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("drain_rw", 64'(regWrite), 64'd1);
      check("drain_wr", 64'(writeR), 64'(k));
      check("drain_wd", 64'(writeRData), 64'(k * 32'h100));
    end
    step();
    check("drain_done", 64'(regWrite), 64'd0);

    // Duplicate destination: bypass returns the youngest value.
    drive(1'b1, 5'd7, 32'h11, 1'b0);
    step();
    drive(1'b1, 5'd7, 32'h22, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0);
    byp_reg1 = 5'd7;
    byp_reg2 = 5'd0;
    #1;
    check("dup_hit1", 64'(byp_hit1), 64'd1);
    check("dup_data1", 64'(byp_data1), 64'h22);
    check("dup_hit2", 64'(byp_hit2), 64'd0);
    check("dup_data2", 64'(byp_data2), 64'd0);
    drain_en = 1'b1;
    step();
    check("dup_wd0", 64'(writeRData), 64'h11);
    step();
    check("dup_wd1", 64'(writeRData), 64'h22);
    drain_en = 1'b0;
    step();

    // Register 0 is accepted but never stored.
    drive(1'b1, 5'd0, 32'hFFFF, 1'b0);
    #1;
    check("r0_ready", 64'(in_ready), 64'd1);
    step();
    drive(1'b0, '0, '0, 1'b1);
    check("r0_count", 64'(count), 64'd0);
    step();
    check("r0_no_write", 64'(regWrite), 64'd0);

    // Steady state: two pending, enqueue and drain every cycle.
    drive(1'b1, 5'd3, 32'h3333, 1'b0);
    step();
    drive(1'b1, 5'd4, 32'h4444, 1'b0);
    step();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, ADDR_W'(k % 7 + 1), $urandom, 1'b1);
      step();
      check("steady_count", 64'(count), 64'd2);
      check("steady_ready", 64'(in_ready), 64'd1);
    end
    drive(1'b0, '0, '0, 1'b1);
    repeat (3) step();

    // Randomized traffic with small register range to force duplicates.
    for (int k = 0; k < 800; k++) begin
      drive(($urandom_range(0, 3) != 0), ADDR_W'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 2) != 0));
      byp_reg1 = ADDR_W'($urandom_range(0, 7));
      byp_reg2 = ADDR_W'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) rst = 1'b0;
      step();
      rst = 1'b1;
    end

    drive(1'b0, '0, '0, 1'b0);
    step();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
